// File: rtl/stream_merge_ordered_if.sv
// rtl/stream_merge_ordered_if.sv - lane-side and merged-side handshake bundle for stream_merge_ordered
interface stream_merge_ordered_if #(
    parameter int unsigned NumOut = 2,
    parameter type         data_t = logic [31:0]
) ();
    logic [NumOut-1:0]        valid_i;
    logic [NumOut-1:0]        ready_o;
    data_t [NumOut-1:0]       data_i;
    logic                     valid_o;
    logic                     ready_i;
    data_t                    data_o;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o
    );
endinterface

// File: rtl/stream_merge_ordered.sv
// rtl/stream_merge_ordered.sv - table-ordered merge of NumOut lanes with per-lane FIFOs
module stream_merge_ordered #(
    parameter int unsigned       NumOut = 2,
    parameter int unsigned       BLen   = 2,
    parameter type               addr_t = logic [$clog2(NumOut)-1:0],
    parameter addr_t [BLen-1:0]  BTable = '0,
    parameter type               data_t = logic [31:0],
    parameter int unsigned       Depth  = 2,
    parameter bit                Cyclic = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    stream_merge_ordered_if.slave bus,
    output logic                  done_o
);
    localparam int unsigned IW = (BLen > 1) ? $clog2(BLen) : 1;
    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    data_t          mem    [NumOut][Depth];
    logic [PW-1:0]  wr_ptr [NumOut];
    logic [PW-1:0]  rd_ptr [NumOut];
    logic [CW-1:0]  cnt    [NumOut];
    logic [IW-1:0]  idx_q;
    logic           done_q;

    logic [NumOut-1:0] full;
    logic [NumOut-1:0] empty;
    logic [NumOut-1:0] push;
    logic [NumOut-1:0] pop;
    addr_t             sel;
    logic              fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full  = '0;
        empty = '0;
        for (int k = 0; k < NumOut; k++) begin
            full[k]  = (cnt[k] == CW'(Depth));
            empty[k] = (cnt[k] == '0);
        end
    end

    // ready depends on stored occupancy only, so a full lane never takes a beat
    // even when its head pops in the same cycle
    assign bus.ready_o = ~full;
    assign push        = bus.valid_i & ~full;

    assign sel         = BTable[idx_q];
    assign bus.valid_o = !empty[sel] && !done_q;
    assign bus.data_o  = mem[sel][rd_ptr[sel]];
    assign fire        = bus.valid_o && bus.ready_i;
    assign done_o      = Cyclic ? 1'b0 : done_q;

    always_comb begin
        pop = '0;
        for (int k = 0; k < NumOut; k++) begin
            pop[k] = fire && (sel == addr_t'(k));
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NumOut; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= bus.data_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumOut; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            for (int k = 0; k < NumOut; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= ptr_inc(wr_ptr[k]);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= ptr_inc(rd_ptr[k]);
                end
                cnt[k] <= cnt[k] + CW'(push[k]) - CW'(pop[k]);
            end
            if (fire) begin
                if (idx_q == IW'(BLen - 1)) begin
                    if (Cyclic) begin
                        idx_q <= '0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < BLen; i++) begin
                assert (int'(BTable[i]) < int'(NumOut))
                    else $error("BTable entry %0d out of lane range", i);
            end
            assert (Depth >= 1) else $error("Depth must be at least 1");
            for (int k = 0; k < NumOut; k++) begin
                assert (!(push[k] && full[k])) else $error("push into full lane %0d", k);
            end
        end
    end
endmodule
